hamming_sec_scrub_ctrl: RTL and testbench

Controller that owns a small 12-bit Hamming-SEC-protected storage array and sequences all accesses to it. Host writes are encoded before storage. Host reads are decoded and corrected, and correctable errors are written back. A background scrubber walks the array during idle time and repairs single-bit upsets. It sits between a byte-wide requester and the protected storage, sharing the array between host traffic and the scrubber.

---
 rtl/hamming_sec_scrub_ctrl.sv | 279 +++++++++++++++++++++++++++
 tb/tb_hamming_sec_scrub_ctrl.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_sec_scrub_ctrl.sv
// hamming_sec_scrub_ctrl
// Owns a 2**ADDR_W x 12-bit Hamming-SEC protected array and arbitrates it
// between a byte-wide host and an optional background scrubber.
//  - Host writes are encoded (plus an injection mask) and stored in one cycle.
//  - Host reads are decoded on the accept edge. The response appears one cycle
//    later, and any single-bit error is repaired in place on that response edge.
//  - Scrubber (present only when HAMMING_SEC_SCRUB_EN is defined): after
//    SCRUB_INTERVAL idle cycles it checks one word and repairs it if needed.
// The addressed word is decoded once, when the read or scrub is launched.
// The decoded result is held in the check register. The following cycle only
// writes the repaired word back and updates the counters.
module hamming_sec_scrub_ctrl #(
  parameter int ADDR_W         = 4,
  parameter int SCRUB_INTERVAL = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [7:0]        req_wdata,
  input  logic [11:0]       req_inj_mask,
  output logic              rsp_valid,
  output logic [7:0]        rsp_data,
  output logic              rsp_corrected,
  output logic              rsp_uncorrectable,
  output logic              scrub_busy,
  output logic [ADDR_W-1:0] scrub_addr,
  output logic [15:0]       corr_count,
  output logic [15:0]       uncorr_count
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_RD_RSP    = 2'd1,
    S_SCRUB_CHK = 2'd2
  } state_t;

  typedef struct packed {
    logic [11:0] fixed;   // codeword after correction (raw if uncorrectable)
    logic [7:0]  data;    // data extracted from 'fixed'
    logic        corr;    // a single bit was flipped
    logic        uncorr;  // syndrome matched no bit position
  } dec_t;

  // Place data bits and compute the four parity bits of the codeword.
  function automatic logic [11:0] hamming_enc(input logic [7:0] d);
    logic [11:0] c;
    c     = 12'h000;
    c[11] = d[7];
    c[10] = d[6];
    c[9]  = d[5];
    c[8]  = d[4];
    c[6]  = d[3];
    c[5]  = d[2];
    c[4]  = d[1];
    c[2]  = d[0];
    c[7]  = c[11] ^ c[10] ^ c[9] ^ c[8];
    c[3]  = c[11] ^ c[6] ^ c[5] ^ c[4];
    c[1]  = c[10] ^ c[9] ^ c[6] ^ c[5] ^ c[2];
    c[0]  = c[10] ^ c[8] ^ c[6] ^ c[4] ^ c[2];
    return c;
  endfunction

  // Syndrome decode: flip the matching bit, or flag the word as uncorrectable.
  function automatic dec_t hamming_dec(input logic [11:0] c);
    dec_t        r;
    logic [3:0]  s;
    logic [11:0] flip;
    s[3]     = c[7] ^ c[11] ^ c[10] ^ c[9] ^ c[8];
    s[2]     = c[3] ^ c[11] ^ c[6] ^ c[5] ^ c[4];
    s[1]     = c[1] ^ c[10] ^ c[9] ^ c[6] ^ c[5] ^ c[2];
    s[0]     = c[0] ^ c[10] ^ c[8] ^ c[6] ^ c[4] ^ c[2];
    flip     = 12'h000;
    r.uncorr = 1'b0;
    case (s)
      4'b0000: flip = 12'h000;
      4'b1000: flip = 12'h080;
      4'b0100: flip = 12'h008;
      4'b0010: flip = 12'h002;
      4'b0001: flip = 12'h001;
      4'b1100: flip = 12'h800;
      4'b1011: flip = 12'h400;
      4'b1010: flip = 12'h200;
      4'b1001: flip = 12'h100;
      4'b0111: flip = 12'h040;
      4'b0110: flip = 12'h020;
      4'b0101: flip = 12'h010;
      4'b0011: flip = 12'h004;
      default: begin
        flip     = 12'h000;
        r.uncorr = 1'b1;
      end
    endcase
    r.corr  = |flip;
    r.fixed = c ^ flip;
    r.data  = {r.fixed[11:8], r.fixed[6:4], r.fixed[2]};
    return r;
  endfunction

  state_t            state_r, state_s;
  logic [11:0]       mem_r [DEPTH];
  dec_t              chk_r;
  logic [ADDR_W-1:0] chk_addr_r;
  logic [15:0]       corr_cnt_r, uncorr_cnt_r;
  logic              req_ready_r, rsp_valid_r, rsp_corr_r, rsp_unc_r;
  logic [7:0]        rsp_data_r;

  logic              accept_wr_s, accept_rd_s, launch_scrub_s, finish_s;
  logic              scrub_due_s;
  logic [ADDR_W-1:0] scrub_addr_s, rd_addr_s;
  dec_t              dec_s;

`ifdef HAMMING_SEC_SCRUB_EN
  localparam int TMR_W = $clog2(SCRUB_INTERVAL);

  logic [TMR_W-1:0]  tmr_r;
  logic [ADDR_W-1:0] scrub_addr_r;
  logic              scrub_busy_r;

  assign scrub_due_s  = (tmr_r == TMR_W'(SCRUB_INTERVAL - 1));
  assign scrub_addr_s = scrub_addr_r;
  assign scrub_busy   = scrub_busy_r;

  // Idle timer (holds while the host is requesting), scrub pointer and busy strobe
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmr_r        <= {TMR_W{1'b0}};
      scrub_addr_r <= {ADDR_W{1'b0}};
      scrub_busy_r <= 1'b0;
    end else begin
      if (launch_scrub_s) begin
        tmr_r <= {TMR_W{1'b0}};
      end else if ((state_r == S_IDLE) && !req_valid) begin
        tmr_r <= tmr_r + TMR_W'(1);
      end
      if (state_r == S_SCRUB_CHK) begin
        scrub_addr_r <= scrub_addr_r + ADDR_W'(1);
      end
      scrub_busy_r <= launch_scrub_s;
    end
  end
`else
  assign scrub_due_s  = 1'b0;
  assign scrub_addr_s = {ADDR_W{1'b0}};
  assign scrub_busy   = 1'b0;
`endif

  assign scrub_addr = scrub_addr_s;

  // Array read port: the host address wins whenever a request is present
  always_comb begin
    rd_addr_s = scrub_addr_s;
    if (req_valid) begin
      rd_addr_s = req_addr;
    end else begin
      rd_addr_s = scrub_addr_s;
    end
    dec_s = hamming_dec(mem_r[rd_addr_s]);
  end

  // Next-state and per-cycle action decode
  always_comb begin
    state_s        = state_r;
    accept_wr_s    = 1'b0;
    accept_rd_s    = 1'b0;
    launch_scrub_s = 1'b0;
    finish_s       = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (req_valid) begin
          if (req_write) begin
            accept_wr_s = 1'b1;
          end else begin
            accept_rd_s = 1'b1;
            state_s     = S_RD_RSP;
          end
        end else if (scrub_due_s) begin
          launch_scrub_s = 1'b1;
          state_s        = S_SCRUB_CHK;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_RD_RSP: begin
        finish_s = 1'b1;
        state_s  = S_IDLE;
      end
`ifdef HAMMING_SEC_SCRUB_EN
      S_SCRUB_CHK: begin
        finish_s = 1'b1;
        state_s  = S_IDLE;
      end
`endif
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Storage array: host write, or repair writeback on the check cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 12'h000;
      end
    end else if (accept_wr_s) begin
      mem_r[req_addr] <= hamming_enc(req_wdata) ^ req_inj_mask;
    end else if (finish_s && chk_r.corr) begin
      mem_r[chk_addr_r] <= chk_r.fixed;
    end
  end

  // Check register: decoded word and its address, captured at launch
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chk_r      <= '{fixed: 12'h000, data: 8'h00, corr: 1'b0, uncorr: 1'b0};
      chk_addr_r <= {ADDR_W{1'b0}};
    end else if (accept_rd_s || launch_scrub_s) begin
      chk_r      <= dec_s;
      chk_addr_r <= rd_addr_s;
    end
  end

  // Saturating event counters, bumped on the check cycle of reads and scrubs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      corr_cnt_r   <= 16'h0000;
      uncorr_cnt_r <= 16'h0000;
    end else if (finish_s) begin
      if (chk_r.corr && (corr_cnt_r != 16'hFFFF)) begin
        corr_cnt_r <= corr_cnt_r + 16'd1;
      end
      if (chk_r.uncorr && (uncorr_cnt_r != 16'hFFFF)) begin
        uncorr_cnt_r <= uncorr_cnt_r + 16'd1;
      end
    end
  end

  // Response and handshake registers: strobe/flags for one cycle, data held
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_corr_r  <= 1'b0;
      rsp_unc_r   <= 1'b0;
      rsp_data_r  <= 8'h00;
    end else begin
      req_ready_r <= (state_s == S_IDLE);
      rsp_valid_r <= accept_rd_s;
      rsp_corr_r  <= accept_rd_s & dec_s.corr;
      rsp_unc_r   <= accept_rd_s & dec_s.uncorr;
      if (accept_rd_s) begin
        rsp_data_r <= dec_s.data;
      end
    end
  end

  assign req_ready         = req_ready_r;
  assign rsp_valid         = rsp_valid_r;
  assign rsp_data          = rsp_data_r;
  assign rsp_corrected     = rsp_corr_r;
  assign rsp_uncorrectable = rsp_unc_r;
  assign corr_count        = corr_cnt_r;
  assign uncorr_count      = uncorr_cnt_r;

endmodule

// File: tb/tb_hamming_sec_scrub_ctrl.sv
// Self-checking bench for hamming_sec_scrub_ctrl.
// The reference model keeps the array as plain codewords. It treats the
// syndrome as the XOR of (position+1) over all set bits, which is the
// classic Hamming position code for this layout.
// Build with or without HAMMING_SEC_SCRUB_EN.
module tb_hamming_sec_scrub_ctrl;
  localparam int ADDR_W         = 4;
  localparam int DEPTH          = 1 << ADDR_W;
  localparam int SCRUB_INTERVAL = 64;
  localparam int OUT_W          = 49;
`ifdef HAMMING_SEC_SCRUB_EN
  localparam bit SCRUB_EN = 1'b1;
`else
  localparam bit SCRUB_EN = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [7:0]        req_wdata;
  logic [11:0]       req_inj_mask;
  logic              rsp_valid;
  logic [7:0]        rsp_data;
  logic              rsp_corrected;
  logic              rsp_uncorrectable;
  logic              scrub_busy;
  logic [ADDR_W-1:0] scrub_addr;
  logic [15:0]       corr_count;
  logic [15:0]       uncorr_count;

  hamming_sec_scrub_ctrl #(.ADDR_W(ADDR_W), .SCRUB_INTERVAL(SCRUB_INTERVAL)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_inj_mask(req_inj_mask),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_corrected(rsp_corrected),
    .rsp_uncorrectable(rsp_uncorrectable), .scrub_busy(scrub_busy),
    .scrub_addr(scrub_addr), .corr_count(corr_count), .uncorr_count(uncorr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [OUT_W-1:0] dut_vec;
  assign dut_vec = {req_ready, rsp_valid, rsp_data, rsp_corrected, rsp_uncorrectable,
                    scrub_busy, scrub_addr, corr_count, uncorr_count};

  // ---------------- reference model ----------------
  logic [11:0]       m_mem [DEPTH];
  int                m_pending;   // 0 none, 1 read response, 2 scrub check
  int                m_timer, m_corr, m_uncorr;
  logic [ADDR_W-1:0] m_saddr, m_op_addr;
  logic [7:0]        m_rsp_data;
  logic              m_ready, m_rsp_valid, m_rsp_corr, m_rsp_unc, m_busy;

  function automatic int syn(input logic [11:0] w);
    int s = 0;
    for (int i = 0; i < 12; i++) if (w[i]) s = s ^ (i + 1);
    return s;
  endfunction

  function automatic logic [11:0] m_enc(input logic [7:0] d);
    logic [11:0] w;
    int s;
    w = {d[7:4], 1'b0, d[3:1], 1'b0, d[0], 2'b00};
    s = syn(w);
    w[7] = s[3]; w[3] = s[2]; w[1] = s[1]; w[0] = s[0];
    return w;
  endfunction

  function automatic logic [11:0] m_fix(input logic [11:0] w);
    int s = syn(w);
    if (s >= 1 && s <= 12) return w ^ (12'h001 << (s - 1));
    return w;
  endfunction

  function automatic logic [7:0] m_data(input logic [11:0] w);
    return {w[11:8], w[6:4], w[2]};
  endfunction

  function automatic logic [OUT_W-1:0] m_vec();
    return {m_ready, m_rsp_valid, m_rsp_data, m_rsp_corr, m_rsp_unc,
            m_busy, m_saddr, m_corr[15:0], m_uncorr[15:0]};
  endfunction

  task automatic m_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 12'h000;
    m_pending = 0; m_timer = 0; m_corr = 0; m_uncorr = 0;
    m_saddr = '0; m_op_addr = '0; m_rsp_data = 8'h00;
    m_ready = 1'b1; m_rsp_valid = 1'b0; m_rsp_corr = 1'b0; m_rsp_unc = 1'b0; m_busy = 1'b0;
  endtask

  // One clock of behaviour, given the inputs presented during that clock.
  task automatic m_step(input logic v, input logic wr, input logic [ADDR_W-1:0] a,
                        input logic [7:0] d, input logic [11:0] msk);
    int s;
    m_rsp_valid = 1'b0; m_rsp_corr = 1'b0; m_rsp_unc = 1'b0; m_busy = 1'b0;
    if (m_pending != 0) begin
      s = syn(m_mem[m_op_addr]);
      if (s >= 1 && s <= 12) begin
        m_mem[m_op_addr] = m_fix(m_mem[m_op_addr]);
        if (m_corr < 65535) m_corr++;
      end else if (s > 12) begin
        if (m_uncorr < 65535) m_uncorr++;
      end
      if (m_pending == 2) m_saddr = m_saddr + 1'b1;
      m_pending = 0;
      m_ready   = 1'b1;
    end else if (v && wr) begin
      m_mem[a] = m_enc(d) ^ msk;
    end else if (v) begin
      s = syn(m_mem[a]);
      m_rsp_valid = 1'b1;
      m_rsp_corr  = (s >= 1 && s <= 12);
      m_rsp_unc   = (s > 12);
      m_rsp_data  = m_data(m_fix(m_mem[a]));
      m_pending = 1; m_op_addr = a; m_ready = 1'b0;
    end else if (SCRUB_EN && m_timer == SCRUB_INTERVAL - 1) begin
      m_timer = 0; m_pending = 2; m_op_addr = m_saddr; m_busy = 1'b1; m_ready = 1'b0;
    end else if (SCRUB_EN) begin
      m_timer++;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic cyc(input logic v, input logic wr, input logic [ADDR_W-1:0] a,
                     input logic [7:0] d, input logic [11:0] msk);
    req_valid = v; req_write = wr; req_addr = a; req_wdata = d; req_inj_mask = msk;
    m_step(v, wr, a, d, msk);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = 8'h00; req_inj_mask = 12'h000;
    m_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_reset();
    checks++;
    if (dut_vec !== m_vec()) begin
      failures++; $display("FAIL reset.outputs got=%h exp=%h", dut_vec, m_vec());
    end
    checks++;
    if ({req_ready, rsp_valid, rsp_data, scrub_busy, corr_count, uncorr_count} !== {1'b1, 1'b0, 8'h00, 1'b0, 16'h0, 16'h0}) begin
      failures++; $display("FAIL reset.const got=%b/%b/%h/%b/%h/%h exp=1/0/00/0/0000/0000",
                           req_ready, rsp_valid, rsp_data, scrub_busy, corr_count, uncorr_count);
    end
  endtask

  task automatic test_read_zero();
    do_reset();
    cyc(1'b1, 1'b0, 4'd3, 8'h00, 12'h000);
    checks++;
    if ({rsp_valid, rsp_data, rsp_corrected, rsp_uncorrectable} !== {1'b1, 8'h00, 1'b0, 1'b0}) begin
      failures++; $display("FAIL read_zero.rsp got=%b/%h/%b/%b exp=1/00/0/0",
                           rsp_valid, rsp_data, rsp_corrected, rsp_uncorrectable);
    end
    cyc(1'b0, 1'b0, 4'd0, 8'h00, 12'h000);
    checks++;
    if (dut_vec !== m_vec()) begin
      failures++; $display("FAIL read_zero.after got=%h exp=%h", dut_vec, m_vec());
    end
  endtask

  task automatic test_write_read();
    do_reset();
    cyc(1'b1, 1'b1, 4'd5, 8'hA5, 12'h000);
    cyc(1'b1, 1'b0, 4'd5, 8'h00, 12'h000);
    checks++;
    if ({req_ready, rsp_valid, rsp_data, rsp_corrected, rsp_uncorrectable} !== {1'b0, 1'b1, 8'hA5, 1'b0, 1'b0}) begin
      failures++; $display("FAIL write_read.rsp got=%b/%b/%h/%b/%b exp=0/1/a5/0/0",
                           req_ready, rsp_valid, rsp_data, rsp_corrected, rsp_uncorrectable);
    end
    cyc(1'b0, 1'b0, 4'd0, 8'h00, 12'h000);
    checks++;
    if ({req_ready, rsp_valid, rsp_data} !== {1'b1, 1'b0, 8'hA5}) begin
      failures++; $display("FAIL write_read.hold got=%b/%b/%h exp=1/0/a5", req_ready, rsp_valid, rsp_data);
    end
  endtask

  task automatic test_correct();
    do_reset();
    cyc(1'b1, 1'b1, 4'd7, 8'hA5, 12'h040);
    cyc(1'b1, 1'b0, 4'd7, 8'h00, 12'h000);
    checks++;
    if ({rsp_valid, rsp_data, rsp_corrected, rsp_uncorrectable} !== {1'b1, 8'hA5, 1'b1, 1'b0}) begin
      failures++; $display("FAIL correct.rsp got=%b/%h/%b/%b exp=1/a5/1/0",
                           rsp_valid, rsp_data, rsp_corrected, rsp_uncorrectable);
    end
    cyc(1'b0, 1'b0, 4'd0, 8'h00, 12'h000);
    checks++;
    if ({corr_count, rsp_corrected} !== {16'd1, 1'b0}) begin
      failures++; $display("FAIL correct.count got=%0d/%b exp=1/0", corr_count, rsp_corrected);
    end
    cyc(1'b1, 1'b0, 4'd7, 8'h00, 12'h000);
    checks++;
    if ({rsp_valid, rsp_data, rsp_corrected, rsp_uncorrectable} !== {1'b1, 8'hA5, 1'b0, 1'b0}) begin
      failures++; $display("FAIL correct.reread got=%b/%h/%b/%b exp=1/a5/0/0",
                           rsp_valid, rsp_data, rsp_corrected, rsp_uncorrectable);
    end
    cyc(1'b0, 1'b0, 4'd0, 8'h00, 12'h000);
    checks++;
    if (dut_vec !== m_vec()) begin
      failures++; $display("FAIL correct.model got=%h exp=%h", dut_vec, m_vec());
    end
  endtask

  task automatic test_uncorrectable();
    do_reset();
    cyc(1'b1, 1'b1, 4'd9, 8'hA5, 12'h801);
    for (int k = 0; k < 2; k++) begin
      cyc(1'b1, 1'b0, 4'd9, 8'h00, 12'h000);
      checks++;
      if ({rsp_valid, rsp_data, rsp_corrected, rsp_uncorrectable} !== {1'b1, 8'h25, 1'b0, 1'b1}) begin
        failures++; $display("FAIL uncorr.rsp%0d got=%b/%h/%b/%b exp=1/25/0/1",
                             k, rsp_valid, rsp_data, rsp_corrected, rsp_uncorrectable);
      end
      cyc(1'b0, 1'b0, 4'd0, 8'h00, 12'h000);
      checks++;
      if ({uncorr_count, corr_count} !== {16'(k + 1), 16'd0}) begin
        failures++; $display("FAIL uncorr.count%0d got=%0d/%0d exp=%0d/0", k, uncorr_count, corr_count, k + 1);
      end
    end
  endtask

  task automatic test_reset_abort();
    do_reset();
    cyc(1'b1, 1'b1, 4'd2, 8'h5A, 12'h010);
    cyc(1'b1, 1'b0, 4'd2, 8'h00, 12'h000);
    do_reset();
    checks++;
    if ({rsp_valid, corr_count, req_ready} !== {1'b0, 16'd0, 1'b1}) begin
      failures++; $display("FAIL abort.state got=%b/%0d/%b exp=0/0/1", rsp_valid, corr_count, req_ready);
    end
    cyc(1'b1, 1'b0, 4'd2, 8'h00, 12'h000);
    checks++;
    if ({rsp_valid, rsp_data, rsp_corrected} !== {1'b1, 8'h00, 1'b0}) begin
      failures++; $display("FAIL abort.cleared got=%b/%h/%b exp=1/00/0", rsp_valid, rsp_data, rsp_corrected);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, ADDR_W'(i + 1), 8'($urandom), 12'h000);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0, ADDR_W'(i % 4 + 1), 8'h00, 12'h000);
      checks++;
      if (dut_vec !== m_vec()) begin
        failures++; $display("FAIL b2b.cycle%0d got=%h exp=%h", i, dut_vec, m_vec());
      end
    end
  endtask

`ifdef HAMMING_SEC_SCRUB_EN
  task automatic test_scrub();
    int pulses = 0;
    do_reset();
    cyc(1'b1, 1'b1, 4'd0, 8'h3C, 12'h100);
    for (int i = 0; i < SCRUB_INTERVAL + 1; i++) begin
      cyc(1'b0, 1'b0, 4'd0, 8'h00, 12'h000);
      if (scrub_busy === 1'b1) pulses++;
      checks++;
      if (scrub_busy !== m_busy) begin
        failures++; $display("FAIL scrub.busy%0d got=%b exp=%b", i, scrub_busy, m_busy);
      end
    end
    checks++;
    if ({corr_count, scrub_addr, 8'(pulses)} !== {16'd1, 4'd1, 8'd1}) begin
      failures++; $display("FAIL scrub.result got=%0d/%0d/%0d exp=1/1/1", corr_count, scrub_addr, pulses);
    end
    cyc(1'b1, 1'b0, 4'd0, 8'h00, 12'h000);
    checks++;
    if ({rsp_valid, rsp_data, rsp_corrected, rsp_uncorrectable} !== {1'b1, 8'h3C, 1'b0, 1'b0}) begin
      failures++; $display("FAIL scrub.reread got=%b/%h/%b/%b exp=1/3c/0/0",
                           rsp_valid, rsp_data, rsp_corrected, rsp_uncorrectable);
    end
  endtask

  task automatic test_scrub_wrap();
    int pulses = 0;
    do_reset();
    for (int i = 0; i < DEPTH * (SCRUB_INTERVAL + 1); i++) begin
      cyc(1'b0, 1'b0, 4'd0, 8'h00, 12'h000);
      if (scrub_busy === 1'b1) pulses++;
      checks++;
      if (dut_vec !== m_vec()) begin
        failures++; $display("FAIL wrap.cycle%0d got=%h exp=%h", i, dut_vec, m_vec());
      end
    end
    checks++;
    if ({scrub_addr, 8'(pulses)} !== {4'd0, 8'(DEPTH)}) begin
      failures++; $display("FAIL wrap.result got=%0d/%0d exp=0/%0d", scrub_addr, pulses, DEPTH);
    end
  endtask

  task automatic test_host_priority();
    do_reset();
    for (int i = 0; i < SCRUB_INTERVAL - 1; i++) cyc(1'b0, 1'b0, 4'd0, 8'h00, 12'h000);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b0, ADDR_W'($urandom), 8'h00, 12'h000);
      checks++;
      if (scrub_busy !== 1'b0) begin
        failures++; $display("FAIL prio.held%0d got=%b exp=0", i, scrub_busy);
      end
    end
    cyc(1'b0, 1'b0, 4'd0, 8'h00, 12'h000);
    checks++;
    if ({scrub_busy, req_ready} !== {1'b1, 1'b0}) begin
      failures++; $display("FAIL prio.fire got=%b/%b exp=1/0", scrub_busy, req_ready);
    end
    cyc(1'b0, 1'b0, 4'd0, 8'h00, 12'h000);
    checks++;
    if (dut_vec !== m_vec()) begin
      failures++; $display("FAIL prio.after got=%h exp=%h", dut_vec, m_vec());
    end
  endtask
`else
  task automatic test_scrub_off();
    do_reset();
    cyc(1'b1, 1'b1, 4'd0, 8'h3C, 12'h100);
    for (int i = 0; i < 3 * SCRUB_INTERVAL; i++) begin
      cyc(1'b0, 1'b0, 4'd0, 8'h00, 12'h000);
      checks++;
      if ({scrub_busy, scrub_addr, corr_count} !== {1'b0, 4'd0, 16'd0}) begin
        failures++; $display("FAIL scrub_off.idle%0d got=%b/%0d/%0d exp=0/0/0", i, scrub_busy, scrub_addr, corr_count);
      end
    end
    cyc(1'b1, 1'b0, 4'd0, 8'h00, 12'h000);
    checks++;
    if ({rsp_data, rsp_corrected} !== {8'h3C, 1'b1}) begin
      failures++; $display("FAIL scrub_off.read got=%h/%b exp=3c/1", rsp_data, rsp_corrected);
    end
  endtask
`endif

  task automatic test_random();
    logic v, wr;
    logic [11:0] msk;
    int r, b0, b1;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      r  = $urandom_range(0, 9);
      v  = (r >= 4);
      wr = (r >= 4 && r < 7);
      r  = $urandom_range(0, 9);
      if (r < 6) begin
        msk = 12'h000;
      end else if (r < 9) begin
        msk = 12'h001 << $urandom_range(0, 11);
      end else begin
        b0 = $urandom_range(0, 11);
        b1 = (b0 + $urandom_range(1, 11)) % 12;
        msk = (12'h001 << b0) | (12'h001 << b1);
      end
      cyc(v, wr, ADDR_W'($urandom), 8'($urandom), msk);
      checks++;
      if (dut_vec !== m_vec()) begin
        failures++; $display("FAIL random.cycle%0d got=%h exp=%h", i, dut_vec, m_vec());
      end
    end
  endtask

  initial begin
    rst_n = 1'b1; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = 8'h00; req_inj_mask = 12'h000;
    m_reset();
    test_reset();
    test_read_zero();
    test_write_read();
    test_correct();
    test_uncorrectable();
    test_reset_abort();
    test_back_to_back();
`ifdef HAMMING_SEC_SCRUB_EN
    test_scrub();
    test_scrub_wrap();
    test_host_priority();
`else
    test_scrub_off();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
